// File: rtl/data_sram_responder_if.sv
// Data SRAM port between the CPU core (master) and the data responder (slave).
// The core presents one request every cycle; there is no handshake.
//   data_sram_we    : write request this cycle
//   data_sram_addr  : byte address, bits [1:0] ignored (word access)
//   data_sram_wdata : write data
//   data_sram_rdata : registered read data for the previous cycle's address
interface data_sram_responder_if;
    logic        data_sram_we;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;

    modport master (
        output data_sram_we,
        output data_sram_addr,
        output data_sram_wdata,
        input  data_sram_rdata
    );

    modport slave (
        input  data_sram_we,
        input  data_sram_addr,
        input  data_sram_wdata,
        output data_sram_rdata
    );
endinterface

// File: rtl/data_sram_responder.sv
// Responder for the CPU data SRAM port. Each cycle's request is decoded into
// a word-addressed data RAM, a small register window (NUM, LED, SWITCH,
// TIMER, SIMU_FLAG) or a miss. Read data is registered (one-cycle latency,
// write-first), behaving like a synchronous block RAM.
// Ports:
//   clk      : single clock, rising edge
//   reset    : synchronous, active-high
//   bus      : data SRAM request/response (slave modport)
//   switch   : board switches, sampled when SWITCH is read
//   led      : LED register output
//   num_data : numeric-display register output
module data_sram_responder #(
    parameter int unsigned RAM_AW    = 12,
    parameter logic [31:0] RAM_BASE  = 32'h1c00_0000,
    parameter logic [31:0] CONF_BASE = 32'hbfaf_0000
) (
    input  logic                        clk,
    input  logic                        reset,
    data_sram_responder_if.slave        bus,
    input  logic [7:0]                  switch,
    output logic [15:0]                 led,
    output logic [31:0]                 num_data
);

    localparam int unsigned RAM_WORDS = 1 << RAM_AW;

    // Register offsets expressed as word offsets (byte offset >> 2).
    localparam logic [13:0] WOFF_NUM    = 14'h3c04;  // 0xf010
    localparam logic [13:0] WOFF_LED    = 14'h3c08;  // 0xf020
    localparam logic [13:0] WOFF_SWITCH = 14'h3c0c;  // 0xf030
    localparam logic [13:0] WOFF_TIMER  = 14'h3800;  // 0xe000
    localparam logic [13:0] WOFF_SIMU   = 14'h3c10;  // 0xf040

    logic [31:0] r_ram [0:RAM_WORDS-1];
    logic [31:0] r_rdata;
    logic [15:0] r_led;
    logic [31:0] r_num;
    logic [31:0] r_timer;

    logic              w_we;
    logic [31:0]       w_addr;
    logic [31:0]       w_wdata;
    logic              w_ram_hit;
    logic              w_conf_sel;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [13:0]       w_conf_off;
    logic              w_wr_num;
    logic              w_wr_led;
    logic              w_wr_timer;
    logic [31:0]       w_rd_next;
    logic              w_unused_addr_lo;

    assign w_we    = bus.data_sram_we;
    assign w_addr  = bus.data_sram_addr;
    assign w_wdata = bus.data_sram_wdata;

    // Byte-lane bits carry no meaning for word accesses.
    assign w_unused_addr_lo = &{1'b0, w_addr[1:0]};

    assign w_ram_hit  = (w_addr[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2]);
    // RAM decode wins should a parameterisation ever make the regions overlap.
    assign w_conf_sel = (w_addr[31:16] == CONF_BASE[31:16]) && !w_ram_hit;
    assign w_ram_idx  = w_addr[RAM_AW+1:2];
    assign w_conf_off = w_addr[15:2];

    assign w_wr_num   = w_we && w_conf_sel && (w_conf_off == WOFF_NUM);
    assign w_wr_led   = w_we && w_conf_sel && (w_conf_off == WOFF_LED);
    assign w_wr_timer = w_we && w_conf_sel && (w_conf_off == WOFF_TIMER);

    // Write-first read mux: a same-cycle write is forwarded as read data,
    // except TIMER, which returns the count held before the edge.
    always_comb begin
        w_rd_next = 32'h0;
        if (w_ram_hit) begin
            w_rd_next = w_we ? w_wdata : r_ram[w_ram_idx];
        end else if (w_conf_sel) begin
            case (w_conf_off)
                WOFF_NUM:    w_rd_next = w_we ? w_wdata : r_num;
                WOFF_LED:    w_rd_next = {16'h0, (w_we ? w_wdata[15:0] : r_led)};
                WOFF_SWITCH: w_rd_next = {24'h0, switch};
                WOFF_TIMER:  w_rd_next = r_timer;
                WOFF_SIMU:   w_rd_next = 32'hffff_ffff;
                default:     w_rd_next = 32'h0;
            endcase
        end
    end

    // RAM array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (!reset && w_we && w_ram_hit) begin
            r_ram[w_ram_idx] <= w_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= 32'h0;
            r_led   <= 16'h0;
            r_num   <= 32'h0;
            r_timer <= 32'h0;
        end else begin
            r_rdata <= w_rd_next;
            if (w_wr_num) begin
                r_num <= w_wdata;
            end
            if (w_wr_led) begin
                r_led <= w_wdata[15:0];
            end
            r_timer <= w_wr_timer ? w_wdata : (r_timer + 32'd1);
        end
    end

    assign bus.data_sram_rdata = r_rdata;
    assign led                 = r_led;
    assign num_data            = r_num;

endmodule

// File: doc/data_sram_responder.md
# data_sram_responder

Responder end of the CPU data SRAM interface: accepts the core's `data_sram_we/addr/wdata` request each cycle and returns `data_sram_rdata`. Decodes each request into either a word-addressed data RAM or a small memory-mapped register window (LED, numeric display, switch input, free-running timer). It sits outside the CPU core in the SoC top and is the only responder on the data port. Read data is registered, giving one-cycle latency, in the manner of a synchronous block RAM.

## Interface
- `RAM_AW`, default 12: RAM word-address bits; RAM holds 2^RAM_AW 32-bit words (16 KB at default).
- `RAM_BASE`, default 32'h1c00_0000: RAM region base; must be aligned to 2^(RAM_AW+2).
- `CONF_BASE`, default 32'hbfaf_0000: register window base; 64 KB window (`addr[31:16]` compared).
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-high.
- `data_sram_we` in 1: write request this cycle.
- `data_sram_addr` in 32: byte address; `[1:0]` ignored (word access only).
- `data_sram_wdata` in 32: write data.
- `data_sram_rdata` out 32: registered read data for the previous cycle's address.
- `switch` in 8: board switch inputs, sampled on read.
- `led` out 16: LED register.
- `num_data` out 32: numeric-display register.

## Operation
- Every cycle is a request: no valid/ready handshake, no stall; responder never backpressures.
- Region decode (combinational on `data_sram_addr`):
  - RAM hit: `addr[31:RAM_AW+2] == RAM_BASE[31:RAM_AW+2]`; word index `addr[RAM_AW+1:2]`.
  - CONF hit: `addr[31:16] == CONF_BASE[31:16]`; offset `addr[15:0]`.
  - Neither: miss.
- Register map (offsets in window):
  - 0xf010 NUM: r/w, 32 bits, drives `num_data`.
  - 0xf020 LED: r/w, low 16 bits stored, drives `led`; read returns {16'b0, led}.
  - 0xf030 SWITCH: read-only, returns {24'b0, switch}; writes ignored.
  - 0xe000 TIMER: r/w, 32-bit counter; +1 every cycle (wraps 32'hffff_ffff -> 0).
  - 0xf040 SIMU_FLAG: read-only, constant 32'hffff_ffff.
  - Any other CONF offset: reads 0, writes ignored.
- RAM: write when `we` and RAM hit. Read is write-first: same-cycle write to the word being read returns the new `wdata`.
- Miss: writes dropped silently; reads return 32'h0.
- Register writes take effect at the clock edge; read of a register in the same cycle as its write returns the new value (write-first, same as RAM).
- TIMER write: counter loads `wdata` at that edge (no +1 that cycle); increments resume the next cycle. TIMER read returns counter value before the edge.

## Timing
- Read latency 1: `data_sram_rdata` at cycle N+1 reflects the address presented at cycle N. It holds until the next edge; it updates every cycle, including cycles with `we`=1.
- Back-to-back requests every cycle at full throughput.
- Reset (synchronous, takes priority over any same-cycle write): `data_sram_rdata`=0, `led`=16'h0000, `num_data`=0, timer=0. RAM contents are not reset and are undefined until written. `switch` and SIMU_FLAG are unaffected.
- Reset mid-stream: a request presented in the reset cycle is discarded (no write, rdata forced 0). The first cycle after reset deasserts is a normal request.
- The timer counts in the first cycle after reset: it reads 0 if addressed in the cycle reset is deasserted, and 1 the cycle after.
- Outputs `led`/`num_data` are direct register outputs with no combinational path from inputs.

## Test plan
- RAM write/read: write 32'hdead_beef to 0x1c00_0010; read 0x1c00_0010 next cycle -> rdata 32'hdead_beef one cycle after the read address. Read 0x1c00_0013 -> same word (`[1:0]` ignored).
- Write-first and wrap: write 32'h1234_5678 with `we`=1 to 0x1c00_3ffc -> rdata 32'h1234_5678 next cycle. Read 0x1c00_4000 (outside 16 KB) -> 0; a write there leaves word 0 unchanged.
- MMIO: write 32'h0000_abcd to 0xbfaf_f020 -> `led`=16'habcd after the edge. Write 32'h8765_4321 to 0xbfaf_f010 -> `num_data`=32'h8765_4321. Set `switch`=8'h5a and read 0xbfaf_f030 -> 32'h0000_005a. Read 0xbfaf_f040 -> 32'hffff_ffff.
- Timer: write 32'hffff_fffe to 0xbfaf_e000 at cycle N. Read TIMER at N+1, N+2, N+3 -> 32'hffff_fffe, 32'hffff_ffff, 32'h0000_0000.
- Reset mid-operation: with `led`=16'habcd and timer running, assert `reset` for one cycle together with a write of 32'h1 to LED -> `led`=0, `num_data`=0, rdata=0, timer restarts from 0. RAM word 0x1c00_0010 still reads 32'hdead_beef.
- Unmapped: write to 0xbfaf_0004 and to 0x0000_0000 -> no register or RAM change; reads of both -> 32'h0.
